// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared UART constants, receiver state type, helpers   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package uart_pkg;

   localparam int UART_OSR       = 16;
   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } uart_rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_2ff : two-flop synchronizer for an asynchronous input       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic d_in,
   output logic q_out
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d_in;
         r_sync <= r_meta;
      end
   end

   assign q_out = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx : oversampled 8N1 receiver with valid/ready byte output  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module uart_rx
   import uart_pkg::*;
#(
   parameter int OSR       = UART_OSR,
   parameter int DATA_BITS = UART_DATA_BITS
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 tick_in,
   input  logic                 rxd_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 frame_err_out,
   output logic                 overrun_out
);

   localparam int TW = $clog2(OSR);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] c_t_s0   = TW'(OSR / 2 - 1);
   localparam logic [TW-1:0] c_t_s1   = TW'(OSR / 2);
   localparam logic [TW-1:0] c_t_dec  = TW'(OSR / 2 + 1);
   localparam logic [TW-1:0] c_t_last = TW'(OSR - 1);
   localparam logic [BW-1:0] c_bits   = BW'(DATA_BITS);

   logic                 w_rxd_s;
   uart_rx_state_t       r_state, w_state_nxt;
   logic [TW-1:0]        r_tcnt, w_tcnt_nxt;
   logic [BW-1:0]        r_bcnt, w_bcnt_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic [1:0]           r_smp, w_smp_nxt;
   logic                 r_dlv, w_dlv_nxt;
   logic                 r_stop, w_stop_nxt;
   logic                 w_maj, w_dec, w_wrap, w_xfer;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .d_in     (rxd_in),
      .q_out    (w_rxd_s)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= IDLE;
         r_tcnt  <= '0;
         r_bcnt  <= '0;
         r_shift <= '0;
         r_smp   <= '0;
         r_dlv   <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_shift <= w_shift_nxt;
         r_smp   <= w_smp_nxt;
         r_dlv   <= w_dlv_nxt;
         r_stop  <= w_stop_nxt;
      end
   end

   // The third majority sample is the live line value on the decision tick.
   assign w_maj  = maj3(r_smp[1], r_smp[0], w_rxd_s);
   assign w_dec  = (r_tcnt == c_t_dec);
   assign w_wrap = (r_tcnt == c_t_last);

   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_bcnt_nxt  = r_bcnt;
      w_shift_nxt = r_shift;
      w_smp_nxt   = r_smp;
      w_dlv_nxt   = 1'b0;
      w_stop_nxt  = r_stop;

      if (tick_in) begin
         if (r_state == START || r_state == DATA || r_state == STOP) begin
            w_tcnt_nxt = w_wrap ? '0 : r_tcnt + TW'(1);
            if (r_tcnt == c_t_s0) w_smp_nxt[1] = w_rxd_s;
            if (r_tcnt == c_t_s1) w_smp_nxt[0] = w_rxd_s;
         end

         case (r_state)
            IDLE: begin
               if (!w_rxd_s) begin
                  w_state_nxt = START;
                  w_tcnt_nxt  = '0;
               end
            end
            START: begin
               if (w_dec && w_maj) begin
                  w_state_nxt = IDLE;
                  w_tcnt_nxt  = '0;
               end else if (w_wrap) begin
                  w_state_nxt = DATA;
                  w_bcnt_nxt  = '0;
               end
            end
            DATA: begin
               if (w_dec) begin
                  w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
                  w_bcnt_nxt  = r_bcnt + BW'(1);
               end
               if (w_wrap && r_bcnt == c_bits) w_state_nxt = STOP;
            end
            STOP: begin
               // Leave half a bit early on a good stop so the next start edge is not missed.
               if (w_dec) begin
                  w_dlv_nxt   = 1'b1;
                  w_stop_nxt  = w_maj;
                  w_tcnt_nxt  = '0;
                  w_state_nxt = w_maj ? IDLE : WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (w_rxd_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign w_xfer = valid_out && ready_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         data_out      <= '0;
         valid_out     <= 1'b0;
         frame_err_out <= 1'b0;
         overrun_out   <= 1'b0;
      end else begin
         if (w_xfer) begin
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
         end
         // A delivery may land in the same cycle as a transfer of the previous byte.
         if (r_dlv) begin
            if (!valid_out || ready_in) begin
               data_out      <= r_shift;
               frame_err_out <= ~r_stop;
               valid_out     <= 1'b1;
            end else begin
               overrun_out <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire
